prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader that writes a 16-bit instruction image into the shared instruction/data RAM's write port. It takes a byte stream from a valid/ready source, such as a UART receiver or a debug bridge, and assembles big-endian words. The loader holds the CPU (FSM plus datapath) idle until the image is complete: it is the writer-side counterpart of the FSM's instruction fetch. After a successful load it asserts `cpu_run`, which gates the CPU's active-low `reset` at the top level.

## Interface
- `ADDR_W`, 10, RAM address width; maximum image size is 2^ADDR_W words.
- `BASE_ADDR`, 0, first RAM word address written.
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins a load.
- `rx_data` in 8: stream byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: the loader accepts a byte this cycle.
- `mem_addr` out ADDR_W: RAM write address.
- `mem_wdata` out 16: RAM write data.
- `mem_we` out 1: RAM write strobe, one cycle per word.
- `cpu_run` out 1: high means release the CPU from reset.
- `busy` out 1: a load is in progress.
- `done` out 1: the image loaded successfully.
- `error` out 1: the load was aborted.
- `words_loaded` out 16: count of words written in the current load.

## Operation
- A byte transfers only in a cycle where `rx_valid` and `rx_ready` are both 1. Bytes offered while `rx_ready` is 0 are not consumed, and the source must hold them.
- Stream format:
  - LEN_HI, then LEN_LO: this is N, the word count.
  - Then N words, each as a high byte followed by a low byte.
  - Then, only with checksum enabled, one CHK byte.
- States and transitions:
  - IDLE: `start` moves to LEN_HI.
  - LEN_HI: on a transfer, moves to LEN_LO.
  - LEN_LO: on a transfer, the next state depends on N.
    - N > 2^ADDR_W: ERROR.
    - N = 0: CHECK if checksum is enabled, otherwise DONE.
    - Otherwise: DATA_HI.
  - DATA_HI: on a transfer, moves to DATA_LO.
  - DATA_LO: on a transfer, moves to WRITE.
  - WRITE: one cycle with `mem_we`=1, `mem_addr`=BASE_ADDR+index and `mem_wdata`={hi,lo}. At the end of the cycle the index increments; the loader moves to DATA_HI if index<N, otherwise to CHECK or DONE.
  - CHECK: on a transfer, moves to DONE or ERROR.
  - DONE: holds.
  - ERROR: holds.
- `rx_ready` is 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK. It is 0 in IDLE, WRITE, DONE and ERROR.
- `busy` is 1 in every state except IDLE, DONE and ERROR.
- `cpu_run` and `done` are 1 only in DONE. `error` is 1 only in ERROR.
- `start` behaviour:
  - In DONE or ERROR, `start` re-enters LEN_HI. This clears `words_loaded`, the index and the checksum, and drops `cpu_run` on the same edge.
  - While `busy` is 1, `start` is ignored.
- `words_loaded` increments on each WRITE cycle. It is held in DONE and ERROR.
- Address arithmetic: BASE_ADDR+index is truncated to ADDR_W bits, so a non-zero BASE_ADDR wraps modulo 2^ADDR_W. Nothing overwrites the loader's own state.
- The loader never reads RAM. RAM contents from a partial load are left as written.

## Timing
- Reset values (asserted asynchronously):
  - State is IDLE.
  - `rx_ready`, `mem_we`, `cpu_run`, `busy`, `done` and `error` are 0.
  - `mem_addr`, `mem_wdata` and `words_loaded` are 0.
- Reset mid-load returns to IDLE immediately, and the CPU stays held because `cpu_run`=0.
- `mem_addr`, `mem_wdata` and `mem_we` are registered. `mem_we` rises on the clock edge that accepts the low byte, and stays high for exactly one cycle.
- Minimum rate is 3 cycles per word: DATA_HI, DATA_LO, WRITE.
- End of load:
  - Without checksum: `done` and `cpu_run` rise on the edge that ends the last WRITE.
  - With checksum: they rise on the edge that accepts the CHK byte.
  - For N=0: they rise on the edge that accepts the LEN_LO byte (no checksum) or the CHK byte (checksum).
- `start` coincident with a transfer in LEN_HI is ignored; the transfer proceeds.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - The running XOR of all data bytes, excluding the length bytes, is compared against the trailing CHK byte.
  - Match goes to DONE; mismatch goes to ERROR with `cpu_run`=0.
- `LOADER_CHECKSUM_EN` undefined:
  - There is no CHECK state and no CHK byte.
  - After the final WRITE, the loader goes directly to DONE.

## Test plan
- Basic load, checksum off, BASE_ADDR=0, stream 00 02 12 34 AB CD:
  - Writes 0x1234 at address 0, then 0xABCD at address 1.
  - `words_loaded`=2, `done`=`cpu_run`=1.
- Backpressure: `rx_valid` is held 1 with a fresh byte every cycle.
  - `rx_ready` is 0 during each WRITE cycle.
  - No byte is lost or duplicated.
  - `mem_we` pulses exactly twice, 3 cycles apart.
- Oversize length, ADDR_W=10, stream 04 01:
  - ERROR after LEN_LO, `rx_ready`=0, no `mem_we`, `cpu_run`=0.
- Checksum on, stream 00 01 12 34 26:
  - The XOR of 12 and 34 is 26, so the load reaches DONE.
  - Repeating with CHK=27 gives ERROR while the word is still written.
- Reset asserted after the first of 3 words:
  - All outputs are 0 asynchronously.
  - A following `start` plus a full stream loads normally, with `words_loaded` restarting at 0.
- Reload from DONE:
  - `start` drops `cpu_run` on the same edge.
  - A zero-length stream 00 00 returns to DONE with `words_loaded`=0.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream / RAM-write bundle for prog_loader.
//   rx_data, rx_valid : byte stream from the source (UART receiver, debug bridge)
//   rx_ready          : loader accepts the offered byte this cycle
//   mem_addr          : RAM write address (ADDR_W bits)
//   mem_wdata         : RAM write data (16 bits)
//   mem_we            : RAM write strobe
// Modport master is the loader side; modport slave is the source/RAM side.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_we;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output mem_addr,
    output mem_wdata,
    output mem_we
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader. Receives a byte stream LEN_HI, LEN_LO, N big-endian words
// (and a trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined), writes the words to
// RAM at BASE_ADDR+index (wrapping modulo 2^ADDR_W) and releases the CPU via cpu_run once the
// image is complete.
// Ports:
//   clk          : system clock, rising edge
//   reset        : asynchronous active-low reset
//   start        : single-cycle pulse that begins a load (ignored while busy)
//   bus          : prog_loader_if.master (byte stream in, RAM write port out)
//   cpu_run      : high releases the CPU from reset (DONE only)
//   busy         : load in progress
//   done         : image loaded successfully
//   error        : load aborted (oversize length or checksum mismatch)
//   words_loaded : words written in the current load
// Optional feature macro: LOADER_CHECKSUM_EN adds the CHECK state and trailing CHK byte.
module prog_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  prog_loader_if.master bus,
  output logic          cpu_run,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [15:0]   words_loaded
);

  localparam int unsigned       MaxWords = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  typedef enum logic [3:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StWrite,
`ifdef LOADER_CHECKSUM_EN
    StCheck,
`endif
    StDone,
    StError
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       index_q, index_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              rx_ready;
  logic [15:0]       len_full;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  // Length as it will be once the LEN_LO byte currently on the bus is taken.
  assign len_full = {len_q[15:8], bus.rx_data};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    hi_d        = hi_q;
    index_d     = index_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    rx_ready    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    chk_d       = chk_q;
`endif
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d = StLenHi;
          index_d = '0;
`ifdef LOADER_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      StLenHi: begin
        rx_ready = 1'b1;
        if (bus.rx_valid) begin
          len_d   = {bus.rx_data, 8'h00};
          state_d = StLenLo;
        end
      end
      StLenLo: begin
        rx_ready = 1'b1;
        if (bus.rx_valid) begin
          len_d = len_full;
          if ({16'd0, len_full} > MaxWords) begin
            state_d = StError;
          end else if (len_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        rx_ready = 1'b1;
        if (bus.rx_valid) begin
          hi_d    = bus.rx_data;
          state_d = StDataLo;
`ifdef LOADER_CHECKSUM_EN
          chk_d   = chk_q ^ bus.rx_data;
`endif
        end
      end
      StDataLo: begin
        rx_ready = 1'b1;
        if (bus.rx_valid) begin
          // Write port is registered: the strobe is high during the following WRITE cycle.
          mem_we_d    = 1'b1;
          mem_addr_d  = BaseAddr + ADDR_W'(index_q);
          mem_wdata_d = {hi_q, bus.rx_data};
          state_d     = StWrite;
`ifdef LOADER_CHECKSUM_EN
          chk_d       = chk_q ^ bus.rx_data;
`endif
        end
      end
      StWrite: begin
        index_d = index_q + 16'd1;
        if (index_d < len_q) begin
          state_d = StDataHi;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        rx_ready = 1'b1;
        if (bus.rx_valid) begin
          state_d = (bus.rx_data == chk_q) ? StDone : StError;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      hi_q        <= '0;
      index_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      index_q     <= index_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign bus.rx_ready  = rx_ready;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;

  assign cpu_run      = (state_q == StDone);
  assign done         = (state_q == StDone);
  assign error        = (state_q == StError);
  assign busy         = !(state_q inside {StIdle, StDone, StError});
  // The write index counts exactly the WRITE cycles of the current load.
  assign words_loaded = index_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned BASE   = 0;
  localparam int          MAXW   = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cpu_run, busy, done, error;
  logic [15:0] words_loaded;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .cpu_run      (cpu_run),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Write monitor: one entry per cycle with mem_we high.
  int                cycle = 0;
  logic [31:0]       wr_addr[$];
  logic [15:0]       wr_data[$];
  int                we_cyc[$];

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(32'(bus.mem_addr));
      wr_data.push_back(bus.mem_wdata);
      we_cyc.push_back(cycle);
      check("rx_ready_low_in_write", 32'(bus.rx_ready), 32'd0);
    end
  end

  // Reference model: expected image, stream bytes and final outcome.
  logic [15:0] exp_words[$];
  logic [7:0]  stream[$];
  bit          exp_ok;
  int          exp_cnt;

  task automatic fill_random(input int n);
    exp_words.delete();
    for (int i = 0; i < n; i++) exp_words.push_back(16'($urandom));
  endtask

  task automatic build(input int n, input bit bad);
    logic [15:0] nn;
    logic [7:0]  x;
    bit          over;
    nn   = 16'(n);
    over = (n > MAXW);
    x    = 8'h00;
    stream.delete();
    stream.push_back(nn[15:8]);
    stream.push_back(nn[7:0]);
    if (!over) begin
      foreach (exp_words[i]) begin
        stream.push_back(exp_words[i][15:8]);
        stream.push_back(exp_words[i][7:0]);
        x = x ^ exp_words[i][15:8] ^ exp_words[i][7:0];
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (!over) stream.push_back(bad ? (x ^ 8'h01) : x);
    exp_ok = !over && !bad;
`else
    exp_ok = !over && (x == x || bad);
`endif
    exp_cnt = over ? 0 : n;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Offers one byte and returns #1 after the edge that consumed it.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc;
    int t;
    if (gaps) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 40) begin
      @(negedge clk);
      acc = bus.rx_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_load(input bit gaps, input bit start_mid);
    int t;
    wr_addr.delete();
    wr_data.delete();
    we_cyc.delete();
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_cpu_run", 32'(cpu_run), 32'd0);
    foreach (stream[i]) begin
      send_byte(stream[i], gaps);
      if (start_mid && i == 0) begin
        bus.rx_valid = 1'b0;
        pulse_start();
      end
    end
    bus.rx_valid = 1'b0;
    t = 0;
    while (busy === 1'b1 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("settle_busy", 32'(busy), 32'd0);
    check("end_done", 32'(done), 32'(exp_ok));
    check("end_error", 32'(error), 32'(!exp_ok));
    check("end_cpu_run", 32'(cpu_run), 32'(exp_ok));
    check("end_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("words_loaded", 32'(words_loaded), 32'(exp_cnt));
    check("write_count", 32'(wr_data.size()), 32'(exp_cnt));
    for (int i = 0; i < exp_cnt && i < wr_data.size(); i++) begin
      check("write_addr", wr_addr[i], 32'((BASE + i) % MAXW));
      check("write_data", 32'(wr_data[i]), 32'(exp_words[i]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit  gaps, bad;
    int  n;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset values.
    #12;
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Basic load 00 02 12 34 AB CD, back-to-back bytes (backpressure case).
    exp_words.delete();
    exp_words.push_back(16'h1234);
    exp_words.push_back(16'hABCD);
    build(2, 1'b0);
    run_load(1'b0, 1'b0);
    check("we_pulses", 32'(we_cyc.size()), 32'd2);
    if (we_cyc.size() == 2) check("we_spacing", 32'(we_cyc[1] - we_cyc[0]), 32'd3);

    // Oversize length 04 01.
    exp_words.delete();
    build(1025, 1'b0);
    run_load(1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    // 00 01 12 34 26 passes; CHK 27 fails but the word is still written.
    exp_words.delete();
    exp_words.push_back(16'h1234);
    build(1, 1'b0);
    check("chk_byte", 32'(stream[4]), 32'h26);
    run_load(1'b1, 1'b0);
    build(1, 1'b1);
    run_load(1'b1, 1'b0);
`endif

    // Start pulse while busy is ignored.
    fill_random(3);
    build(3, 1'b0);
    run_load(1'b1, 1'b1);

    // Reset after the first of three words.
    fill_random(3);
    exp_words[0][15] = 1'b1;
    build(3, 1'b0);
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(stream[i], 1'b0);
    bus.rx_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_reset_words", 32'(words_loaded), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check("arst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("arst_mem_we", 32'(bus.mem_we), 32'd0);
    check("arst_cpu_run", 32'(cpu_run), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_error", 32'(error), 32'd0);
    check("arst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("arst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("arst_words", 32'(words_loaded), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    fill_random(3);
    build(3, 1'b0);
    run_load(1'b1, 1'b0);

    // Reload from DONE with a zero-length stream.
    check("reload_from_done", 32'(done), 32'd1);
    exp_words.delete();
    build(0, 1'b0);
    run_load(1'b0, 1'b0);

    // Largest legal image: 2^ADDR_W words.
    fill_random(MAXW);
    build(MAXW, 1'b0);
    run_load(1'b0, 1'b0);

    // Randomised loads.
    for (int k = 0; k < 12; k++) begin
      gaps = 1'($urandom_range(0, 1));
      bad  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      bad = ($urandom_range(0, 3) == 0);
`endif
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(MAXW + 1, 65535);
        exp_words.delete();
      end else begin
        n = $urandom_range(0, 6);
        fill_random(n);
      end
      build(n, bad);
      run_load(gaps, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
